gc_scan_cfg_loader: RTL

//  Serialises configuration words into a chain of GC scan flip-flops (scan-enable DFF, async clear).

---
 rtl/gc_cfg_pkg.sv | 21 ++
 rtl/gc_cfg_serializer.sv | 40 ++++
 rtl/gc_scan_cfg_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gc_cfg_pkg.sv
// Shared types for the GC scan configuration loader: FSM state encoding and a width helper.
package gc_cfg_pkg;

  localparam logic [1:0] GC_ST_IDLE  = 2'd0;
  localparam logic [1:0] GC_ST_LOAD  = 2'd1;
  localparam logic [1:0] GC_ST_SHIFT = 2'd2;
  localparam logic [1:0] GC_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = GC_ST_IDLE,
    LOAD  = GC_ST_LOAD,
    SHIFT = GC_ST_SHIFT,
    DONE  = GC_ST_DONE
  } gc_ldr_state_t;

  // Index width for a word of w bits; a 1-bit word still needs a 1-bit index.
  function automatic int gc_idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/gc_cfg_serializer.sv
// Parallel-load shift register that presents one configuration bit per shift, bit0 first,
// with the current bit index and a flag marking the last bit of the word.
module gc_cfg_serializer
  import gc_cfg_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = gc_idx_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              shift,
  output logic              si,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              word_last
);

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= data;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      idx   <= word_last ? '0 : idx + IDX_W'(1);
    end
  end

  // si comes straight from a flop so the chain sees a glitch-free, registered bit.
  assign si        = shreg[0];
  assign bit_idx   = idx;
  assign word_last = (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/gc_scan_cfg_loader.sv
// Streams configuration words bit-serially into a GC scan chain and pulses done after CHAIN_LEN bits.
// Build option GC_SCAN_CFG_LOADER_READBACK_EN adds a deserialiser for the displaced chain contents.
module gc_scan_cfg_loader
  import gc_cfg_pkg::*;
#(
  parameter int  CHAIN_LEN = 1024,
  parameter int  WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_si,
  output logic              scan_se,
  input  logic              scan_so,
  output logic              ff_en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = gc_idx_width(WORD_W);

  gc_ldr_state_t    state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             accept, shift_en, word_last, chain_last, bit_last, scan_se_q;

  // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready; cfg_ready is high
  // only in LOAD and does not depend on cfg_valid, and the word is consumed in full before the next.
  assign cfg_ready  = (state == LOAD);
  assign accept     = cfg_valid && cfg_ready;
  assign shift_en   = (state == SHIFT);
  assign chain_last = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign bit_last   = word_last || chain_last;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept) state_next = SHIFT;
      SHIFT:   if (bit_last) state_next = chain_last ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      scan_se_q <= 1'b0;
    end else begin
      state     <= state_next;
      scan_se_q <= (state_next == SHIFT);
      if (state == IDLE && start) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  gc_cfg_serializer #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_ser (
    .clk       (C),
    .rst_n     (R),
    .load      (accept),
    .data      (cfg_data),
    .shift     (shift_en),
    .si        (scan_si),
    .bit_idx   (bit_idx),
    .word_last (word_last)
  );

  // Cells hold (E=0, SE=0) whenever the loader owns the chain but is not shifting.
  assign scan_se   = scan_se_q;
  assign ff_en     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

`ifdef GC_SCAN_CFG_LOADER_READBACK_EN
  logic [WORD_W-1:0] rb_q, rb_next, rd_data_q;
  logic              rd_valid_q;

  always_comb begin
    rb_next          = rb_q;
    rb_next[bit_idx] = scan_so;
  end

  // Each shift cycle captures the bit leaving the chain; a group closes with its word.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rb_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state == SHIFT) begin
        if (bit_last) begin
          rd_data_q  <= rb_next;
          rd_valid_q <= 1'b1;
          rb_q       <= '0;
        end else begin
          rb_q <= rb_next;
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_rb;
  assign unused_rb = scan_so ^ (^bit_idx);
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule
